// File: rtl/barret_pkg.sv
// barret_pkg: shared definitions for the Barrett-reduction request scheduler.
// Holds the scheduler state encoding, the default sizing constants and a
// small index helper used for round-robin pointer wrap.
package barret_pkg;

  localparam int DEF_WIDTH      = 32;
  localparam int DEF_NREQ       = 4;
  localparam int DEF_BR_LATENCY = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Next index after idx in a ring of n entries.
  function automatic int wrap_inc(input int idx, input int n);
    if (idx + 1 >= n) begin
      return 0;
    end else begin
      return idx + 1;
    end
  endfunction

endpackage

// File: rtl/barret_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
// Searches req starting at index ptr and wrapping modulo NREQ; the first set
// bit found wins.
//   req       in  NREQ          request vector
//   ptr       in  clog2(NREQ)   highest-priority index for this pick
//   grant     out NREQ          one-hot grant (zero when no request)
//   grant_idx out clog2(NREQ)   index of the granted bit
//   grant_any out 1             a grant was made
module rr_arbiter
  import barret_pkg::*;
#(
  parameter int NREQ = DEF_NREQ
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] grant_idx,
  output logic                    grant_any
);

  localparam int IDW = $clog2(NREQ);

  logic [IDW-1:0] cand_s;

  // Walk the ring from ptr and keep the first requester seen.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand_s    = '0;
    for (int off = 0; off < NREQ; off++) begin
      cand_s = IDW'((int'(ptr) + off) % NREQ);
      if (!grant_any && req[cand_s]) begin
        grant[cand_s] = 1'b1;
        grant_idx     = cand_s;
        grant_any     = 1'b1;
      end else begin
        grant_any = grant_any;
      end
    end
  end

endmodule

// File: rtl/barret_scheduler.sv
// barret_scheduler: shares one barretReduce core among NREQ requesters.
// A round-robin grant in IDLE latches the winner's operands, the core is
// started for one cycle, the remainder is captured BR_LATENCY cycles later
// and held as a response until the consumer accepts it. A zero denominator
// bypasses the core and answers immediately with resp_err set.
//   sys_clk, sys_rst               clock, synchronous active-high reset
//   req_valid / req_ready          per-requester handshake (ready one-hot)
//   req_numerator .. req_constant  packed operands, requester i at [i*WIDTH +: WIDTH]
//   resp_valid / resp_ready        response handshake
//   resp_id, resp_remainder, resp_err  response payload
//   br_start, br_numerator .. br_constant, br_remainder  core connection
//   busy                           high whenever not IDLE
module barret_scheduler
  import barret_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int NREQ       = DEF_NREQ,
  parameter int BR_LATENCY = DEF_BR_LATENCY
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*WIDTH-1:0]     req_numerator,
  input  logic [NREQ*WIDTH-1:0]     req_denominator,
  input  logic [NREQ*WIDTH-1:0]     req_R,
  input  logic [NREQ*WIDTH-1:0]     req_constant,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [$clog2(NREQ)-1:0]   resp_id,
  output logic [WIDTH-1:0]          resp_remainder,
  output logic                      resp_err,
  output logic                      br_start,
  output logic [WIDTH-1:0]          br_numerator,
  output logic [WIDTH-1:0]          br_denominator,
  output logic [WIDTH-1:0]          br_R,
  output logic [WIDTH-1:0]          br_constant,
  input  logic [WIDTH-1:0]          br_remainder,
  output logic                      busy
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(BR_LATENCY + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(BR_LATENCY);

  state_t           state_r, state_s;
  logic [IDW-1:0]   rr_ptr_r;
  logic [CW-1:0]    cnt_r;
  logic [IDW-1:0]   id_r;
  logic [WIDTH-1:0] num_r, den_r, r_r, const_r;
  logic             resp_valid_r, resp_err_r, br_start_r, busy_r;
  logic [IDW-1:0]   resp_id_r;
  logic [WIDTH-1:0] resp_rem_r;

  logic [NREQ-1:0]  grant_s;
  logic [IDW-1:0]   grant_idx_s;
  logic             grant_any_s;
  logic             take_s;
  logic [NREQ-1:0]  req_ready_s;
  logic [WIDTH-1:0] sel_num_s, sel_den_s, sel_r_s, sel_const_s;

  rr_arbiter #(.NREQ(NREQ)) u_rr_arbiter (
    .req       (req_valid),
    .ptr       (rr_ptr_r),
    .grant     (grant_s),
    .grant_idx (grant_idx_s),
    .grant_any (grant_any_s)
  );

  assign sel_num_s   = req_numerator  [int'(grant_idx_s)*WIDTH +: WIDTH];
  assign sel_den_s   = req_denominator[int'(grant_idx_s)*WIDTH +: WIDTH];
  assign sel_r_s     = req_R          [int'(grant_idx_s)*WIDTH +: WIDTH];
  assign sel_const_s = req_constant   [int'(grant_idx_s)*WIDTH +: WIDTH];

  // Next-state and grant decode; the accept strobe is only ever raised in IDLE.
  always_comb begin
    state_s     = state_r;
    req_ready_s = '0;
    take_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (grant_any_s) begin
          req_ready_s = grant_s;
          take_s      = 1'b1;
          if (sel_den_s == '0) begin
            state_s = ST_RESP;
          end else begin
            state_s = ST_ISSUE;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: state_s = ST_WAIT;
      ST_WAIT: begin
        if (cnt_r <= CNT_ONE) begin
          state_s = ST_RESP;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RESP;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // The grant decode is combinational off req_valid, so mask it during reset.
  assign req_ready = sys_rst ? '0 : req_ready_s;

  // State, operand latch, wait counter, response registers and pointer.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_r      <= ST_IDLE;
      rr_ptr_r     <= '0;
      cnt_r        <= '0;
      id_r         <= '0;
      num_r        <= '0;
      den_r        <= '0;
      r_r          <= '0;
      const_r      <= '0;
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
      resp_id_r    <= '0;
      resp_rem_r   <= '0;
      br_start_r   <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r    <= state_s;
      busy_r     <= (state_s != ST_IDLE);
      br_start_r <= (state_s == ST_ISSUE);
      case (state_r)
        ST_IDLE: begin
          if (take_s) begin
            id_r    <= grant_idx_s;
            num_r   <= sel_num_s;
            den_r   <= sel_den_s;
            r_r     <= sel_r_s;
            const_r <= sel_const_s;
            // Divide-by-zero answers straight away without touching the core.
            if (sel_den_s == '0) begin
              resp_valid_r <= 1'b1;
              resp_id_r    <= grant_idx_s;
              resp_rem_r   <= '0;
              resp_err_r   <= 1'b1;
            end else begin
              resp_valid_r <= 1'b0;
            end
          end else begin
            resp_valid_r <= 1'b0;
          end
        end
        ST_ISSUE: cnt_r <= CNT_LOAD;
        ST_WAIT: begin
          // Counter at one means the core output is valid in this cycle.
          if (cnt_r <= CNT_ONE) begin
            cnt_r        <= '0;
            resp_valid_r <= 1'b1;
            resp_id_r    <= id_r;
            resp_rem_r   <= br_remainder;
            resp_err_r   <= 1'b0;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid_r <= 1'b0;
            rr_ptr_r     <= IDW'(wrap_inc(int'(id_r), NREQ));
          end else begin
            resp_valid_r <= 1'b1;
          end
        end
        default: resp_valid_r <= 1'b0;
      endcase
    end
  end

  assign resp_valid     = resp_valid_r;
  assign resp_id        = resp_id_r;
  assign resp_remainder = resp_rem_r;
  assign resp_err       = resp_err_r;
  assign br_start       = br_start_r;
  assign br_numerator   = num_r;
  assign br_denominator = den_r;
  assign br_R           = r_r;
  assign br_constant    = const_r;
  assign busy           = busy_r;

endmodule

// File: tb/tb_barret_scheduler.sv
// tb_barret_scheduler: directed scenarios plus a randomized run against a
// transaction-level model (round-robin pick, modulo arithmetic, fixed latency).
// A behavioural stand-in for the barretReduce core answers num % den exactly
// BR_LATENCY cycles after br_start and drives noise on every other cycle.
module tb_barret_scheduler;

  localparam int WIDTH = 32;
  localparam int NREQ  = 4;
  localparam int L     = 4;
  localparam int IDW   = 2;

  logic                  sys_clk = 1'b0;
  logic                  sys_rst;
  logic [NREQ-1:0]       req_valid, req_ready;
  logic [NREQ*WIDTH-1:0] req_numerator, req_denominator, req_R, req_constant;
  logic                  resp_valid, resp_ready, resp_err, br_start, busy;
  logic [IDW-1:0]        resp_id;
  logic [WIDTH-1:0]      resp_remainder, br_numerator, br_denominator, br_R, br_constant, br_remainder;

  logic [WIDTH-1:0] num_a [NREQ];
  logic [WIDTH-1:0] den_a [NREQ];
  logic [WIDTH-1:0] r_a   [NREQ];
  logic [WIDTH-1:0] c_a   [NREQ];

  int vectors = 0;
  int miscompares = 0;
  int br_start_cnt = 0;
  int age = -1;
  logic [WIDTH-1:0] snap_num, snap_den, snap_r, snap_c, bm_res;

  barret_scheduler #(.WIDTH(WIDTH), .NREQ(NREQ), .BR_LATENCY(L)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_numerator(req_numerator), .req_denominator(req_denominator),
    .req_R(req_R), .req_constant(req_constant),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_remainder(resp_remainder), .resp_err(resp_err),
    .br_start(br_start), .br_numerator(br_numerator), .br_denominator(br_denominator),
    .br_R(br_R), .br_constant(br_constant), .br_remainder(br_remainder),
    .busy(busy)
  );

  always #5 sys_clk = ~sys_clk;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_numerator[i*WIDTH +: WIDTH]   = num_a[i];
      req_denominator[i*WIDTH +: WIDTH] = den_a[i];
      req_R[i*WIDTH +: WIDTH]           = r_a[i];
      req_constant[i*WIDTH +: WIDTH]    = c_a[i];
    end
  end

  function automatic logic [WIDTH-1:0] ref_mod(input logic [WIDTH-1:0] n, input logic [WIDTH-1:0] d);
    if (d == '0) return '0;
    return n % d;
  endfunction

  // Core stand-in plus operand-stability watch from start to capture cycle.
  always @(negedge sys_clk) begin
    if (sys_rst) begin
      age = -1;
      br_remainder = $urandom;
    end else begin
      if (age >= 0) age++;
      if (age > L) age = -1;
      if (age >= 1) begin
        vectors++;
        if (br_start !== 1'b0 || br_numerator !== snap_num || br_denominator !== snap_den ||
            br_R !== snap_r || br_constant !== snap_c) begin
          miscompares++;
          $display("FAIL br_operand_stability: got start=%0b num=%0h den=%0h R=%0h c=%0h, expected start=0 num=%0h den=%0h R=%0h c=%0h",
                   br_start, br_numerator, br_denominator, br_R, br_constant, snap_num, snap_den, snap_r, snap_c);
        end
      end
      if (br_start) begin
        br_start_cnt++;
        if (age < 0) begin
          age = 0;
          snap_num = br_numerator; snap_den = br_denominator; snap_r = br_R; snap_c = br_constant;
          bm_res = ref_mod(br_numerator, br_denominator);
        end
      end
      br_remainder = (age == L) ? bm_res : $urandom;
    end
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  task automatic rand_ops(input int i, input logic zero_ok);
    int sel;
    sel = $urandom_range(0, 7);
    num_a[i] = $urandom;
    r_a[i]   = $urandom;
    c_a[i]   = $urandom;
    if (zero_ok && sel == 0) den_a[i] = '0;
    else if (sel < 5)        den_a[i] = WIDTH'($urandom_range(1, 300));
    else                     den_a[i] = $urandom | 32'd1;
  endtask

  task automatic do_reset;
    @(posedge sys_clk); #1;
    sys_rst = 1'b1; req_valid = '0;
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;
  endtask

  task automatic test_reset;
    sys_rst = 1'b1; req_valid = '1; resp_ready = 1'b1;
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    vectors++; if (req_ready !== 4'b0000) begin miscompares++; $display("FAIL reset_req_ready: got %0b, expected 0", req_ready); end
    vectors++; if (br_start !== 1'b0) begin miscompares++; $display("FAIL reset_br_start: got %0b, expected 0", br_start); end
    vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_resp_valid: got %0b, expected 0", resp_valid); end
    vectors++; if (resp_err !== 1'b0) begin miscompares++; $display("FAIL reset_resp_err: got %0b, expected 0", resp_err); end
    vectors++; if (resp_id !== 2'd0) begin miscompares++; $display("FAIL reset_resp_id: got %0d, expected 0", resp_id); end
    vectors++; if (resp_remainder !== 32'd0) begin miscompares++; $display("FAIL reset_resp_remainder: got %0h, expected 0", resp_remainder); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %0b, expected 0", busy); end
    @(posedge sys_clk); #1;
    sys_rst = 1'b0; req_valid = '0;
  endtask

  task automatic test_single;
    int s0, lat;
    logic found;
    num_a[2] = 32'd100; den_a[2] = 32'd7; r_a[2] = 32'd613566756; c_a[2] = 32'd32;
    req_valid = 4'b0100; resp_ready = 1'b1;
    s0 = br_start_cnt; lat = 0; found = 1'b0;
    @(negedge sys_clk);
    vectors++; if (req_ready !== 4'b0100) begin miscompares++; $display("FAIL single_grant: got %0b, expected 0100", req_ready); end
    @(posedge sys_clk); #1;
    req_valid = '0; rand_ops(2, 1'b1);
    for (int c = 0; c < 30 && !found; c++) begin
      @(negedge sys_clk); lat++;
      if (resp_valid) found = 1'b1;
    end
    vectors++; if (found !== 1'b1 || lat != L + 2) begin miscompares++; $display("FAIL single_latency: got %0d cycles (found=%0b), expected %0d", lat, found, L + 2); end
    vectors++; if (resp_remainder !== 32'd2) begin miscompares++; $display("FAIL single_remainder: got %0d, expected 2", resp_remainder); end
    vectors++; if (resp_id !== 2'd2) begin miscompares++; $display("FAIL single_id: got %0d, expected 2", resp_id); end
    vectors++; if (resp_err !== 1'b0) begin miscompares++; $display("FAIL single_err: got %0b, expected 0", resp_err); end
    vectors++; if (br_start_cnt - s0 != 1) begin miscompares++; $display("FAIL single_start_pulses: got %0d, expected 1", br_start_cnt - s0); end
    @(negedge sys_clk);
    vectors++; if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL single_resp_drop: got %0b, expected 0", resp_valid); end
  endtask

  task automatic test_round_robin;
    int exp_order [5] = '{0, 1, 2, 3, 0};
    int got;
    logic [NREQ-1:0] exp_v;
    do_reset();
    for (int i = 0; i < NREQ; i++) rand_ops(i, 1'b0);
    req_valid = '1; resp_ready = 1'b1; got = 0;
    for (int c = 0; c < 200 && got < 5; c++) begin
      @(negedge sys_clk);
      if (req_ready != '0) begin
        exp_v = 4'b0001 << exp_order[got];
        vectors++; if (req_ready !== exp_v) begin miscompares++; $display("FAIL rr_grant_%0d: got %0b, expected %0b", got, req_ready, exp_v); end
        got++;
      end
    end
    vectors++; if (got != 5) begin miscompares++; $display("FAIL rr_grant_count: got %0d, expected 5", got); end
    @(posedge sys_clk); #1;
    req_valid = '0;
  endtask

  task automatic test_backpressure;
    logic [WIDTH-1:0] exp_rem;
    logic found;
    do_reset();
    rand_ops(3, 1'b0);
    exp_rem = ref_mod(num_a[3], den_a[3]);
    req_valid = 4'b1000; resp_ready = 1'b0; found = 1'b0;
    @(negedge sys_clk);
    vectors++; if (req_ready !== 4'b1000) begin miscompares++; $display("FAIL bp_grant: got %0b, expected 1000", req_ready); end
    @(posedge sys_clk); #1;
    req_valid = '1;
    for (int i = 0; i < NREQ; i++) rand_ops(i, 1'b0);
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge sys_clk);
      if (resp_valid) found = 1'b1;
    end
    vectors++; if (found !== 1'b1) begin miscompares++; $display("FAIL bp_resp_seen: got %0b, expected 1", found); end
    for (int c = 0; c < 10; c++) begin
      @(negedge sys_clk);
      vectors++;
      if (resp_valid !== 1'b1 || resp_id !== 2'd3 || resp_remainder !== exp_rem || resp_err !== 1'b0 || req_ready !== 4'b0000) begin
        miscompares++;
        $display("FAIL bp_hold_%0d: got valid=%0b id=%0d rem=%0h err=%0b ready=%0b, expected valid=1 id=3 rem=%0h err=0 ready=0",
                 c, resp_valid, resp_id, resp_remainder, resp_err, req_ready, exp_rem);
      end
    end
    @(posedge sys_clk); #1;
    resp_ready = 1'b1;
    @(negedge sys_clk);
    vectors++; if (req_ready !== 4'b0000 || resp_valid !== 1'b1) begin miscompares++; $display("FAIL bp_complete_cycle: got ready=%0b valid=%0b, expected ready=0 valid=1", req_ready, resp_valid); end
    @(negedge sys_clk);
    vectors++; if (resp_valid !== 1'b0 || req_ready !== 4'b0001) begin miscompares++; $display("FAIL bp_next_grant: got valid=%0b ready=%0b, expected valid=0 ready=0001", resp_valid, req_ready); end
    @(posedge sys_clk); #1;
    req_valid = '0;
  endtask

  task automatic test_zero_den;
    int s0;
    do_reset();
    num_a[1] = $urandom; den_a[1] = '0;
    req_valid = 4'b0010; resp_ready = 1'b1; s0 = br_start_cnt;
    @(negedge sys_clk);
    vectors++; if (req_ready !== 4'b0010) begin miscompares++; $display("FAIL zero_grant: got %0b, expected 0010", req_ready); end
    @(posedge sys_clk); #1;
    req_valid = '0;
    @(negedge sys_clk);
    vectors++; if (resp_valid !== 1'b1 || resp_err !== 1'b1) begin miscompares++; $display("FAIL zero_resp: got valid=%0b err=%0b, expected valid=1 err=1", resp_valid, resp_err); end
    vectors++; if (resp_remainder !== 32'd0 || resp_id !== 2'd1) begin miscompares++; $display("FAIL zero_payload: got rem=%0h id=%0d, expected rem=0 id=1", resp_remainder, resp_id); end
    repeat (6) @(negedge sys_clk);
    vectors++; if (br_start_cnt != s0) begin miscompares++; $display("FAIL zero_no_start: got %0d pulses, expected 0", br_start_cnt - s0); end
  endtask

  task automatic test_reset_mid;
    logic [WIDTH-1:0] exp_rem;
    logic seen, found;
    do_reset();
    rand_ops(2, 1'b0);
    req_valid = 4'b0100; resp_ready = 1'b1; seen = 1'b0; found = 1'b0;
    @(negedge sys_clk);
    vectors++; if (req_ready !== 4'b0100) begin miscompares++; $display("FAIL rmid_grant: got %0b, expected 0100", req_ready); end
    @(posedge sys_clk); #1;
    req_valid = '0;
    repeat (2) @(posedge sys_clk);
    #1 sys_rst = 1'b1;
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;
    @(negedge sys_clk);
    vectors++;
    if (resp_valid !== 1'b0 || busy !== 1'b0 || br_start !== 1'b0 || req_ready !== 4'b0000 ||
        resp_id !== 2'd0 || resp_remainder !== 32'd0 || resp_err !== 1'b0) begin
      miscompares++;
      $display("FAIL rmid_reset_values: got valid=%0b busy=%0b start=%0b ready=%0b id=%0d rem=%0h err=%0b, expected all 0",
               resp_valid, busy, br_start, req_ready, resp_id, resp_remainder, resp_err);
    end
    for (int c = 0; c < L + 4; c++) begin
      @(negedge sys_clk);
      if (resp_valid) seen = 1'b1;
    end
    vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL rmid_no_resp: got %0b, expected 0", seen); end
    @(posedge sys_clk); #1;
    for (int i = 0; i < NREQ; i++) rand_ops(i, 1'b0);
    exp_rem = ref_mod(num_a[0], den_a[0]);
    req_valid = '1;
    @(negedge sys_clk);
    vectors++; if (req_ready !== 4'b0001) begin miscompares++; $display("FAIL rmid_regrant: got %0b, expected 0001", req_ready); end
    @(posedge sys_clk); #1;
    req_valid = '0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge sys_clk);
      if (resp_valid) found = 1'b1;
    end
    vectors++; if (found !== 1'b1 || resp_id !== 2'd0 || resp_remainder !== exp_rem) begin miscompares++; $display("FAIL rmid_after: got found=%0b id=%0d rem=%0h, expected found=1 id=0 rem=%0h", found, resp_id, resp_remainder, exp_rem); end
  endtask

  task automatic test_random;
    int ptr, phase, k, lat, done, cyc;
    logic [IDW-1:0]   exp_id;
    logic [WIDTH-1:0] exp_rem;
    logic             exp_err, exp_busy;
    logic [NREQ-1:0]  exp_rdy;
    ptr = 0; phase = 0; k = 0; lat = 0; done = 0; cyc = 0;
    exp_id = '0; exp_rem = '0; exp_err = 1'b0;
    do_reset();
    while (done < 1000 && cyc < 40000) begin
      cyc++;
      for (int i = 0; i < NREQ; i++) rand_ops(i, 1'b1);
      req_valid  = NREQ'($urandom_range(0, 15));
      resp_ready = ($urandom_range(0, 3) != 0);
      @(negedge sys_clk);
      exp_busy = (phase != 0);
      vectors++; if (busy !== exp_busy) begin miscompares++; $display("FAIL rand_busy: got %0b, expected %0b (cycle %0d)", busy, exp_busy, cyc); end
      if (phase == 0) begin
        exp_rdy = '0;
        for (int off = 0; off < NREQ; off++) begin
          int idx;
          idx = (ptr + off) % NREQ;
          if (exp_rdy == '0 && req_valid[idx]) begin exp_rdy[idx] = 1'b1; exp_id = IDW'(idx); end
        end
        vectors++;
        if (req_ready !== exp_rdy || resp_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL rand_idle_grant: got ready=%0b valid=%0b, expected ready=%0b valid=0 (cycle %0d)", req_ready, resp_valid, exp_rdy, cyc);
        end
        if (exp_rdy != '0) begin
          exp_rem = ref_mod(num_a[exp_id], den_a[exp_id]);
          exp_err = (den_a[exp_id] == '0);
          lat = exp_err ? 1 : L + 2;
          k = 0; phase = 1;
        end
      end else if (phase == 1) begin
        k++;
        if (k < lat) begin
          vectors++;
          if (req_ready !== 4'b0000 || resp_valid !== 1'b0) begin miscompares++; $display("FAIL rand_busy_quiet: got ready=%0b valid=%0b, expected 0 0 (cycle %0d)", req_ready, resp_valid, cyc); end
        end else begin
          phase = 2;
        end
      end
      if (phase == 2) begin
        vectors++;
        if (resp_valid !== 1'b1 || resp_id !== exp_id || resp_remainder !== exp_rem || resp_err !== exp_err || req_ready !== 4'b0000) begin
          miscompares++;
          $display("FAIL rand_resp: got valid=%0b id=%0d rem=%0h err=%0b ready=%0b, expected valid=1 id=%0d rem=%0h err=%0b ready=0 (cycle %0d)",
                   resp_valid, resp_id, resp_remainder, resp_err, req_ready, exp_id, exp_rem, exp_err, cyc);
        end
        if (resp_ready) begin
          ptr = (int'(exp_id) + 1) % NREQ;
          phase = 0; done++;
        end
      end
      @(posedge sys_clk); #1;
    end
    vectors++; if (done < 1000) begin miscompares++; $display("FAIL rand_completion: got %0d responses, expected 1000", done); end
    req_valid = '0;
  endtask

  initial begin
    sys_rst = 1'b1; req_valid = '0; resp_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) rand_ops(i, 1'b1);
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_zero_den();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
